// File: rtl/conv2d_stream_engine_pkg.sv
// rtl/conv2d_stream_engine_pkg.sv - shared types, accumulator sizing and round/saturate helper
package conv2d_stream_engine_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int KERNEL_SIZE = 3;

   typedef logic signed [DATA_WIDTH-1:0] pixel_t;
   typedef logic signed [DATA_WIDTH-1:0] coef_t;

   function automatic int acc_width(input int dw, input int k);
      return 2 * dw + $clog2(k * k);
   endfunction

   // Row-major window position -> coefficient index (0 = top-left).
   function automatic int win_idx(input int r, input int c, input int k);
      return r * k + c;
   endfunction

   // Round half-up, arithmetic shift, clamp to a dw-bit signed range.
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                    input int frac, input int dw);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = acc;
      if (frac > 0) r = r + (64'sd1 <<< (frac - 1));
      r  = r >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// rtl/conv2d_stream_engine_if.sv - pixel/result streams and coefficient write port
interface conv2d_stream_engine_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3
);
   localparam int ADDR_WIDTH = $clog2(KERNEL_SIZE * KERNEL_SIZE);

   logic                         coef_we;
   logic [ADDR_WIDTH-1:0]        coef_addr;
   logic signed [DATA_WIDTH-1:0] coef_data;
   logic                         s_valid;
   logic                         s_ready;
   logic signed [DATA_WIDTH-1:0] s_data;
   logic                         m_valid;
   logic                         m_ready;
   logic signed [DATA_WIDTH-1:0] m_data;
   logic                         m_last;

   modport slave (
      input  coef_we, coef_addr, coef_data, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

   modport master (
      output coef_we, coef_addr, coef_data, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/conv2d_stream_engine_line_buffer.sv
// rtl/conv2d_stream_engine_line_buffer.sv - one-row delay memory, read-before-write at the column address
module conv2d_stream_engine_line_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 32,
   parameter int AW         = 5
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [AW-1:0]                addr,
   input  logic signed [DATA_WIDTH-1:0] din,
   output logic signed [DATA_WIDTH-1:0] dout
);
   logic signed [DATA_WIDTH-1:0] mem [DEPTH];

   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= din;
   end
endmodule

// File: rtl/conv2d_stream_engine.sv
// rtl/conv2d_stream_engine.sv - streaming KxK convolution; CONV_RELU_EN clamps negative results to 0
module conv2d_stream_engine
   import conv2d_stream_engine_pkg::*;
#(
   parameter int DATA_WIDTH  = conv2d_stream_engine_pkg::DATA_WIDTH,
   parameter int KERNEL_SIZE = conv2d_stream_engine_pkg::KERNEL_SIZE,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32,
   parameter int FRAC_BITS   = 8,
   parameter logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] COEF_INIT = '0
) (
   input logic clk,
   input logic reset,
   conv2d_stream_engine_if.slave bus
);
   localparam int K         = KERNEL_SIZE;
   localparam int NT        = K * K;
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, K);
   localparam int LV        = $clog2(NT);
   localparam int NP        = 1 << LV;
   localparam int NR        = (LV + 1) / 2;
   localparam int CW        = $clog2(IMG_WIDTH);
   localparam int RW        = $clog2(IMG_HEIGHT);
   localparam int PW        = 2 * DATA_WIDTH;

   typedef logic signed [DATA_WIDTH-1:0] data_t;

   logic            en;
   logic            accept;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   data_t           coef    [NT];
   data_t           coef_s1 [NT];
   data_t           win     [K][K];
   data_t           col_in  [K];
   data_t           lb_out  [K-1];
   logic signed [PW-1:0] prod [NT];
   logic [NR+1:0]   vld;
   logic [NR+1:0]   lst;
   logic            m_valid_q;
   logic            m_last_q;
   data_t           m_data_q;
   data_t           res;

   assign en          = !m_valid_q || bus.m_ready;
   assign accept      = bus.s_valid && en;
   assign bus.s_ready = en;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_last  = m_last_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == CW'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NT; i++) coef[i] <= COEF_INIT[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (bus.coef_we && (int'(bus.coef_addr) < NT)) begin
         coef[bus.coef_addr] <= bus.coef_data;
      end
   end

   // Line buffer g delays by g+1 rows; all share the column counter as address.
   for (genvar g = 0; g < K - 1; g++) begin : g_lb
      data_t lb_din;
      if (g == 0) begin : g_first
         assign lb_din = bus.s_data;
      end else begin : g_next
         assign lb_din = lb_out[g-1];
      end
      conv2d_stream_engine_line_buffer #(
         .DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)
      ) u_lb (
         .clk(clk), .wr_en(accept), .addr(col), .din(lb_din), .dout(lb_out[g])
      );
   end

   always_comb begin
      for (int r = 0; r < K - 1; r++) col_in[r] = lb_out[K-2-r];
      col_in[K-1] = bus.s_data;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
            win[r][K-1] <= col_in[r];
         end
      end
   end

   // Coefficients are snapshotted alongside the window so a same-cycle write hits only later pixels.
   always_ff @(posedge clk) begin
      if (en) begin
         coef_s1 <= coef;
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               prod[win_idx(r, c, K)] <= PW'(win[r][c]) * PW'(coef_s1[win_idx(r, c, K)]);
      end
   end

   // Adder tree: level l sums pairs of level l-1; even levels and the root are registered.
   for (genvar l = 0; l <= LV; l++) begin : g_lvl
      logic signed [ACC_WIDTH-1:0] node [NP >> l];
      if (l == 0) begin : g_leaf
         for (genvar i = 0; i < NP; i++) begin : g_in
            if (i < NT) begin : g_p
               assign node[i] = ACC_WIDTH'(prod[i]);
            end else begin : g_z
               assign node[i] = '0;
            end
         end
      end else if (((l % 2) == 0) || (l == LV)) begin : g_reg
         always_ff @(posedge clk) begin
            if (en)
               for (int i = 0; i < (NP >> l); i++)
                  node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
         end
      end else begin : g_comb
         always_comb begin
            for (int i = 0; i < (NP >> l); i++)
               node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
         lst <= '0;
      end else if (en) begin
         vld <= {vld[NR:0], accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1))};
         lst <= {lst[NR:0], accept && (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1))};
      end
   end

   always_comb begin
      res = data_t'(sat_round(64'(g_lvl[LV].node[0]), FRAC_BITS, DATA_WIDTH));
`ifdef CONV_RELU_EN
      if (res[DATA_WIDTH-1]) res = '0;
`else
      res = res;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else if (en) begin
         m_valid_q <= vld[NR+1];
         m_last_q  <= lst[NR+1];
         m_data_q  <= res;
      end
   end
endmodule
